// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg
// Shared types and helpers for the multi-cycle multiply/divide unit.
//   muldiv_op_t    : operation code carried on the 3-bit op port.
//   muldiv_state_t : FSM state encoding.
//   abs_val()      : two's-complement magnitude of a sign-extended operand.
package mips_muldiv_pkg;

    // Working width of abs_val. Callers sign-extend their operand up to
    // MAX_W and size-cast the result back down, so any WIDTH < MAX_W works.
    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    // The S_ prefix keeps the state names apart from the DIV opcode literal.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } muldiv_state_t;

    // x is the operand sign-extended to MAX_W bits. With signed_en low the
    // value passes through unchanged, so its low bits are the raw operand.
    // The most negative WIDTH-bit value maps to 2^(WIDTH-1), which still
    // fits in WIDTH bits as an unsigned magnitude.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                 input logic             signed_en);
        if (signed_en && x[MAX_W-1]) begin
            return -x;
        end
        return x;
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// mips_muldiv_step
// One iteration of the radix-2 multiply/divide datapath (purely combinational).
// The unit keeps a single 2*WIDTH scratch register acc:
//   multiply : acc = {partial product, remaining multiplier bits}
//   divide   : acc = {partial remainder, dividend bits / quotient bits}
// Ports:
//   div_mode : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in   : scratch register before the step
//   opnd     : multiplicand (multiply) or divisor (divide) magnitude
//   acc_out  : scratch register after the step
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    always_comb begin
        // Multiply: add the multiplicand into the upper half when the current
        // multiplier bit (acc bit 0) is set, then shift the whole accumulator
        // right by one, keeping the carry as the new top bit.
        mul_addend = acc_in[0] ? opnd : '0;
        mul_sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

        // Divide: shift the next dividend bit into the partial remainder.
        // The shifted remainder needs WIDTH+1 bits (the carry bit); when the
        // trial subtract succeeds the difference is below the divisor, so a
        // WIDTH-bit modular subtract gives the exact new remainder.
        div_shift = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_sub   = div_shift[WIDTH-1:0] - opnd;

        if (!div_mode) begin
            acc_out = {mul_sum, acc_in[WIDTH-1:1]};
        end else if (div_ge) begin
            acc_out = {div_sub, acc_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {div_shift[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv
// Multi-cycle integer multiply/divide unit with architectural HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (iterative, WIDTH+1 cycles busy) and
// MTHI, MTLO (single edge, no busy).
//
// Handshake: start is sampled only on an edge where busy is low. A mul/div
// start raises busy from that edge; busy stays high for WIDTH+1 cycles and
// falls in the same cycle that done pulses high for exactly one cycle, at
// which point hi/lo already hold the result. start while busy is ignored,
// never queued. flush while busy abandons the operation at the next edge
// (no done, hi/lo untouched); flush beats start in an idle cycle.
//
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start, op   : request and operation code (muldiv_op_t)
//   op_a, op_b  : rs / rt operands
//   flush       : abort in-flight operation
//   busy        : FSM not idle
//   done        : one-cycle pulse when a mul/div result lands in hi/lo
//   div_by_zero : qualifies done for a divide with op_b == 0
//   hi, lo      : architectural HI/LO registers
//   state_dbg   : current FSM state (muldiv_state_t encoding)
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    muldiv_op_t         op_e;
    muldiv_state_t      state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               neg_res_q;   // negate product / quotient in FIX
    logic               neg_rem_q;   // negate remainder in FIX
    logic               dbz_q;       // current divide has a zero divisor
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dbz_out_q;

    // Issue-side decode
    logic               op_signed;
    logic               op_div;
    logic               op_arith;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // FIX-stage result shaping
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign op_e = muldiv_op_t'(op);

    always_comb begin
        op_signed = (op_e == MULT) || (op_e == DIV);
        op_div    = (op_e == DIV)  || (op_e == DIVU);
        op_arith  = op_signed || (op_e == MULTU) || (op_e == DIVU);
        // Always sign-extend; abs_val only negates when op_signed is set,
        // so unsigned ops get their raw bits back after the size cast.
        mag_a = WIDTH'(abs_val(MAX_W'($signed(op_a)), op_signed));
        mag_b = WIDTH'(abs_val(MAX_W'($signed(op_b)), op_signed));
    end

    mips_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_mode (is_div_q),
        .acc_in   (acc_q),
        .opnd     (opnd_q),
        .acc_out  (acc_step)
    );

    always_comb begin
        quot     = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        prod_fix = neg_res_q ? -acc_q : acc_q;
        if (is_div_q) begin
            // With a zero divisor the iterations leave rem = |op_a|, so the
            // remainder sign fix restores op_a; the quotient is forced to
            // all ones regardless of operand signs.
            fix_lo = dbz_q ? '1 : (neg_res_q ? -quot : quot);
            fix_hi = neg_rem_q ? -rem : rem;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (op_e == MTHI) begin
                            hi_q <= op_a;
                        end else if (op_e == MTLO) begin
                            lo_q <= op_a;
                        end else if (op_arith) begin
                            state_q   <= op_div ? S_DIV : S_MUL;
                            cnt_q     <= '0;
                            // Multiply: low half holds the multiplier and the
                            // multiplicand is added. Divide: low half holds
                            // the dividend and the divisor is subtracted.
                            acc_q     <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                            opnd_q    <= op_div ? mag_b : mag_a;
                            is_div_q  <= op_div;
                            neg_res_q <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            neg_rem_q <= op_signed && op_a[WIDTH-1];
                            dbz_q     <= op_div && (op_b == '0);
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!flush) begin
                        hi_q      <= fix_hi;
                        lo_q      <= fix_lo;
                        done_q    <= 1'b1;
                        dbz_out_q <= dbz_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv
// Self-checking bench for mips_muldiv (WIDTH = 32): a vector table of
// mul/div operations with known expected results, randomised
// vectors against a behavioural model, and hand-written sequences for
// MTHI/MTLO, start-while-busy, flush (mid-op, FIX cycle, idle with start)
// and asynchronous reset mid-operation.
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   state_dbg;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mips_muldiv #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .state_dbg   (state_dbg)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dbz;
    } vec_t;

    vec_t         vecs[$];
    logic [2*W:0] exp_q[$];    // {div_by_zero, hi, lo}
    logic [2*W:0] exp_e;
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic, written independently of the iterative datapath.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] h,
                                  output logic [W-1:0] l);
        int              sa;
        int              sb;
        longint          sp;
        longint unsigned up;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = {32'd0, a} * {32'd0, b};
        h  = '0;
        l  = '0;
        case (o)
            3'd0: {h, l} = sp;
            3'd1: {h, l} = up;
            3'd2: begin l = sa / sb; h = sa % sb; end
            3'd3: begin l = a / b;   h = a % b;   end
            default: ;
        endcase
    endfunction

    // ---------------- scoreboard: compare on every done pulse ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 hi=%0h lo=%0h expected no done", hi, lo);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_hi",  64'(hi), 64'(exp_e[2*W-1:W]));
                check("sb_lo",  64'(lo), 64'(exp_e[W-1:0]));
                check("sb_dbz", 64'(div_by_zero), 64'(exp_e[2*W]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    // Presents a request for exactly one rising edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op    = o;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string name);
        int cycles;
        exp_q.push_back({v.exp_dbz, v.exp_hi, v.exp_lo});
        model_hi = v.exp_hi;
        model_lo = v.exp_lo;
        issue(v.op, v.a, v.b);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(cycles), 64'(W + 1));
        check({name, "_done"}, 64'(done), 64'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int     cycles;
        vec_t   v;
        logic [W-1:0] h;
        logic [W-1:0] l;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        op_a  = '0;
        op_b  = '0;
        model_hi = '0;
        model_lo = '0;

        // op, a, b, expected hi, expected lo, expected div_by_zero
        vecs.push_back('{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        vecs.push_back('{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
        vecs.push_back('{DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
        vecs.push_back('{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        1'b0});
        vecs.push_back('{MULTU, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0});

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi",   64'(hi), 64'd0);
        check("rst_lo",   64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz",  64'(div_by_zero), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(S_IDLE));
        rst = 1'b0;

        // Table vectors
        foreach (vecs[i]) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Random vectors against the model
        for (int i = 0; i < 8; i++) begin
            v.op = 3'($urandom_range(0, 3));
            v.a  = $urandom;
            v.b  = (v.op >= 3'd2) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (v.op == 3'd2 && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 32'd3;
            model(v.op, v.a, v.b, h, l);
            v.exp_hi  = h;
            v.exp_lo  = l;
            v.exp_dbz = 1'b0;
            run_op(v, $sformatf("rnd%0d", i));
        end

        // MTHI / MTLO take effect at the accepting edge with no busy
        issue(MTHI, 32'h11111111, 32'h0);
        check("mthi_hi",   64'(hi), 64'h11111111);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(MTLO, 32'h22222222, 32'h0);
        check("mtlo_lo",   64'(lo), 64'h22222222);
        check("mtlo_hi",   64'(hi), 64'h11111111);
        model_hi = 32'h11111111;
        model_lo = 32'h22222222;

        // DIVU 100/7, ignored start at cycle 5, flush at cycle 10
        issue(DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        op = MULT; op_a = 32'd2; op_b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hi", 64'(hi), 64'(model_hi));
        check("flush_lo", 64'(lo), 64'(model_lo));
        check("flush_stays_idle", 64'(busy), 64'd0);
        issue(MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_after_flush", 64'(hi), 64'hDEADBEEF);
        model_hi = 32'hDEADBEEF;

        // Flush landing on the FIX cycle: no write, no done
        issue(MULT, 32'd3, 32'd3);
        repeat (W) @(negedge clk);
        check("fix_state", 64'(state_dbg), 64'(S_FIX));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fixflush_busy", 64'(busy), 64'd0);
        check("fixflush_done", 64'(done), 64'd0);
        check("fixflush_hi", 64'(hi), 64'(model_hi));
        check("fixflush_lo", 64'(lo), 64'(model_lo));

        // Flush and start together while idle: start dropped
        @(negedge clk);
        op = MULT; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idleflush_busy", 64'(busy), 64'd0);
        op = MTLO; op_a = 32'hCAFEF00D; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idleflush_lo", 64'(lo), 64'(model_lo));

        // start while busy is ignored (MTHI mid-multiply must not touch hi)
        exp_q.push_back({1'b0, 32'd0, 32'd42});
        issue(MULTU, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        op = MTHI; op_a = 32'h00000099; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 4;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        check("busy_start_cycles", 64'(cycles), 64'(W + 1));
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_lo", 64'(lo), 64'd42);
        @(negedge clk);

        // Asynchronous reset in the middle of a MULT
        issue(MULT, 32'd5, 32'd5);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_hi",   64'(hi), 64'd0);
        check("async_rst_lo",   64'(lo), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{MULTU, 32'd3, 32'd4, 32'd0, 32'h0000000C, 1'b0};
        run_op(v, "post_rst_multu");

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
Parametrised, multi-cycle integer multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the MIPS core and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It is a generalisation of the combinational ALU: it adds configurable width, an iterative radix-2 datapath, a start/busy/done handshake and flush support. The core stalls MFHI/MFLO and any new mul/div issue while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>=4, even).
CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived; do not override).

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
op  input  3  operation code (muldiv_op_t): MULT, MULTU, DIV, DIVU, MTHI, MTLO.
op_a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source).
op_b  input  WIDTH  rt operand (multiplier/divisor).
flush  input  1  abort the in-flight operation.
busy  output  1  high while the FSM is not IDLE.
done  output  1  one-cycle pulse when HI/LO receive a mul/div result.
div_by_zero  output  1  high together with done when a DIV/DIVU had op_b=0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and scratch registers cleared. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start + MTHI/MTLO: hi (or lo) <= op_a at that edge. No busy, no done.
- IDLE + start + mul/div: latch |op_a|, |op_b| (two's-complement magnitudes for signed ops; raw values for unsigned), the result-sign bits and count=0. Go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator. After WIDTH iterations go to FIX.
- DIV: restoring divide, one quotient bit per cycle; a WIDTH-bit remainder plus a carry bit. After WIDTH iterations go to FIX.
- FIX: negate the product (sign = a^b) for signed MULT. For signed DIV, negate the quotient (sign = a^b) and the remainder (sign = a). Then write hi/lo, pulse done for one cycle, and return to IDLE.
- Latency: start accepted at edge t; hi/lo updated and done=1 after edge t+WIDTH+1. busy=1 from edge t through edge t+WIDTH+1; busy falls in the same cycle done rises.
- MULT/MULTU: {hi,lo} = 2*WIDTH-bit product.
- DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero: no trap. Result is lo = all ones, hi = op_a (unsigned view). div_by_zero=1 with done. Full latency still applies.
- Signed overflow (MIN / -1): lo = MIN, hi = 0. Magnitude arithmetic plus FIX produces this naturally; no special case.
- start while busy=1: ignored. hi/lo/op unaffected; no queueing.
- flush=1 while busy: return to IDLE at the next edge. hi/lo unchanged; no done.
- flush and start in the same IDLE cycle: flush wins, start is dropped.
- flush in the FIX cycle: hi/lo are not written.
- hi/lo change only on the done edge, on MTHI/MTLO, or on reset.

Decomposition:
- Package mips_muldiv_pkg holds:
  - muldiv_op_t enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - muldiv_state_t enum: IDLE, MUL, DIV, FIX.
  - Function abs_val(x, signed_en).
- One sub-module, mips_muldiv_step: purely combinational single-iteration datapath.
  - Multiply step: conditional add plus shift.
  - Divide step: trial subtract, restore, quotient bit.
- The FSM, counter and HI/LO registers live in mips_muldiv.

Test Plan:
1. Reset, then MULT a=FFFFFFFD (-3), b=00000005 -> after 33 cycles done=1, hi=FFFFFFFF, lo=FFFFFFF1; busy high for exactly 33 cycles.
2. MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
3. DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
4. DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678, div_by_zero=1 with done.
5. Start DIVU 100/7; pulse start with MULT 2*2 at cycle 5; flush at cycle 10 -> no done, hi/lo keep their prior values. A following MTHI a=DEADBEEF sets hi=DEADBEEF at the next edge.
6. Assert rst at cycle 15 of a MULT -> hi=lo=0 and busy=0 immediately (async). A new MULTU 3*4 then gives lo=0000000C, hi=0.
